// File: rtl/stash_merge_out_pkg.sv
// rtl/stash_merge_out_pkg.sv - shared encodings and widths for the stash/serve merge path
package stash_merge_out_pkg;

  typedef enum logic [1:0] {
    MRG_IDLE = 2'd0,
    MRG_OP0  = 2'd1,
    MRG_OP1  = 2'd2
  } mrg_state_t;

  localparam logic SRC_OP0 = 1'b0;
  localparam logic SRC_OP1 = 1'b1;

  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_TUSER_WIDTH = 128;
  localparam int STARVE_WIDTH    = 8;

  function automatic logic [STARVE_WIDTH-1:0] starve_inc(input logic [STARVE_WIDTH-1:0] v);
    return (v == '1) ? v : v + STARVE_WIDTH'(1);
  endfunction

endpackage

// File: rtl/stash_merge_out_fifo.sv
// rtl/stash_merge_out_fifo.sv - fall-through packet FIFO feeding the merge arbiter
// Head entry is visible on dout whenever empty is low; a pop just advances the read pointer.
module stash_merge_out_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE    = {{MAX_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL   = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
  localparam logic [MAX_DEPTH_BITS:0]   CNT_NEARLY = {1'b0, {MAX_DEPTH_BITS{1'b1}}};
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE    = {{(MAX_DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr       = wr_en && (count != CNT_FULL);
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];
  assign empty       = (count == '0);
  // One slot of slack so a combinational ready never races a same-cycle write.
  assign nearly_full = (count >= CNT_NEARLY);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stash_merge_out.sv
// rtl/stash_merge_out.sv - packet-atomic merge of op0 serve and op1 stash streams onto one output
// op0 has priority; a starvation counter forces an op1 packet after STARVE_LIMIT op0 grants.
module stash_merge_out
  import stash_merge_out_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int IN_FIFO_DEPTH_BITS   = 6,
  parameter int STARVE_LIMIT         = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_op0_serve_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_op0_serve_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_op0_serve_tuser,
  input  logic                              s_op0_serve_tlast,
  input  logic                              s_op0_serve_tvalid,
  output logic                              s_op0_serve_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_op1_stash_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_op1_stash_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_op1_stash_tuser,
  input  logic                              s_op1_stash_tlast,
  input  logic                              s_op1_stash_tvalid,
  output logic                              s_op1_stash_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [CNT_WIDTH-1:0]              o_op0_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              o_op1_pkt_cnt
);
  localparam int KEEP_WIDTH = C_S_AXIS_DATA_WIDTH / 8;
  localparam int FIFO_WIDTH = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + KEEP_WIDTH + 1;
  localparam logic [STARVE_WIDTH-1:0] STARVE_LIM = STARVE_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [FIFO_WIDTH-1:0]   op0_dout;
  logic [FIFO_WIDTH-1:0]   op1_dout;
  logic                    op0_empty;
  logic                    op1_empty;
  logic                    op0_nfull;
  logic                    op1_nfull;
  logic                    op0_rd;
  logic                    op1_rd;

  mrg_state_t              state;
  mrg_state_t              state_n;
  logic [STARVE_WIDTH-1:0] starve_cnt;
  logic [STARVE_WIDTH-1:0] starve_n;
  logic                    out_src;
  logic                    adv;
  logic                    load;
  logic                    clear_out;
  logic                    drop_valid;
  logic                    head_src;
  logic [FIFO_WIDTH-1:0]   head;

  assign s_op0_serve_tready = !op0_nfull;
  assign s_op1_stash_tready = !op1_nfull;

  stash_merge_out_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BITS)
  ) u_op0_fifo (
    .clk         (axis_aclk),
    .reset       (axis_reset),
    .din         ({s_op0_serve_tdata, s_op0_serve_tuser, s_op0_serve_tkeep, s_op0_serve_tlast}),
    .wr_en       (s_op0_serve_tvalid && s_op0_serve_tready),
    .rd_en       (op0_rd),
    .dout        (op0_dout),
    .empty       (op0_empty),
    .nearly_full (op0_nfull)
  );

  stash_merge_out_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BITS)
  ) u_op1_fifo (
    .clk         (axis_aclk),
    .reset       (axis_reset),
    .din         ({s_op1_stash_tdata, s_op1_stash_tuser, s_op1_stash_tkeep, s_op1_stash_tlast}),
    .wr_en       (s_op1_stash_tvalid && s_op1_stash_tready),
    .rd_en       (op1_rd),
    .dout        (op1_dout),
    .empty       (op1_empty),
    .nearly_full (op1_nfull)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state      <= MRG_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
    end
  end

  // The FIFO entry's bit 0 is tlast, so head[0] decides the return to arbitration.
  always_comb begin
    state_n    = state;
    starve_n   = starve_cnt;
    op0_rd     = 1'b0;
    op1_rd     = 1'b0;
    load       = 1'b0;
    clear_out  = 1'b0;
    drop_valid = 1'b0;
    head       = op0_dout;
    head_src   = SRC_OP0;
    adv        = !m_axis_tvalid || m_axis_tready;
    case (state)
      MRG_IDLE: begin
        clear_out = adv;
        if (!op1_empty && (op0_empty || starve_cnt >= STARVE_LIM)) begin
          state_n  = MRG_OP1;
          starve_n = '0;
        end else if (!op0_empty) begin
          state_n  = MRG_OP0;
          starve_n = op1_empty ? '0 : starve_inc(starve_cnt);
        end
      end
      MRG_OP0: begin
        if (adv) begin
          if (!op0_empty) begin
            op0_rd = 1'b1;
            load   = 1'b1;
            if (op0_dout[0]) state_n = MRG_IDLE;
          end else begin
            drop_valid = 1'b1;
          end
        end
      end
      MRG_OP1: begin
        head     = op1_dout;
        head_src = SRC_OP1;
        if (adv) begin
          if (!op1_empty) begin
            op1_rd = 1'b1;
            load   = 1'b1;
            if (op1_dout[0]) state_n = MRG_IDLE;
          end else begin
            drop_valid = 1'b1;
          end
        end
      end
      default: state_n = MRG_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset || clear_out) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      out_src       <= SRC_OP0;
    end else if (load) begin
      {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast} <= head;
      m_axis_tvalid <= 1'b1;
      out_src       <= head_src;
    end else if (drop_valid) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      o_op0_pkt_cnt <= '0;
      o_op1_pkt_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      if (out_src == SRC_OP1) o_op1_pkt_cnt <= o_op1_pkt_cnt + CNT_ONE;
      else                    o_op0_pkt_cnt <= o_op0_pkt_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_stash_merge_out.sv
// tb/tb_stash_merge_out.sv - self-checking bench for stash_merge_out
module tb_stash_merge_out;

  localparam int LIM = 4;

  typedef struct {
    int n0;
    int len0;
    int n1;
    int len1;
    int mode;
    int exp_cnt0;
    int exp_cnt1;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    logic [127:0] user;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  logic         clk;
  logic         rst;
  logic [255:0] s0_tdata, s1_tdata, m_tdata;
  logic [31:0]  s0_tkeep, s1_tkeep, m_tkeep;
  logic [127:0] s0_tuser, s1_tuser, m_tuser;
  logic         s0_tlast, s1_tlast, m_tlast;
  logic         s0_tvalid, s1_tvalid, m_tvalid;
  logic         s0_tready, s1_tready, m_tready;
  logic [31:0]  cnt0, cnt1;

  int    n_chk = 0;
  int    n_pass = 0;
  int    acc0 = 0;
  beat_t got[$];
  beat_t exp_q[$];
  logic         prev_stall = 1'b0;
  logic [255:0] prev_data;
  logic         prev_last;

  stash_merge_out dut (
    .axis_aclk          (clk),
    .axis_reset         (rst),
    .s_op0_serve_tdata  (s0_tdata),
    .s_op0_serve_tkeep  (s0_tkeep),
    .s_op0_serve_tuser  (s0_tuser),
    .s_op0_serve_tlast  (s0_tlast),
    .s_op0_serve_tvalid (s0_tvalid),
    .s_op0_serve_tready (s0_tready),
    .s_op1_stash_tdata  (s1_tdata),
    .s_op1_stash_tkeep  (s1_tkeep),
    .s_op1_stash_tuser  (s1_tuser),
    .s_op1_stash_tlast  (s1_tlast),
    .s_op1_stash_tvalid (s1_tvalid),
    .s_op1_stash_tready (s1_tready),
    .m_axis_tdata       (m_tdata),
    .m_axis_tkeep       (m_tkeep),
    .m_axis_tuser       (m_tuser),
    .m_axis_tlast       (m_tlast),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tready      (m_tready),
    .o_op0_pkt_cnt      (cnt0),
    .o_op1_pkt_cnt      (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic beat_t mkbeat(input logic [255:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.user = ~d[127:0];
    b.keep = d[31:0] ^ 32'hFFFF0000;
    b.last = last;
    return b;
  endfunction

  function automatic logic [255:0] mk(input int src, input int p, input int b);
    return {32'hD00D0000 | 32'(src), 192'h0, 8'(src), 8'(p), 8'(b), 8'h5A};
  endfunction

  // Output monitor: records handshaken beats and checks hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {255'h0, m_tvalid}, 256'h1);
        chk("hold_beat", {m_tdata[254:0], m_tlast}, {prev_data[254:0], prev_last});
      end
      if (m_tvalid && m_tready) got.push_back('{m_tdata, m_tuser, m_tkeep, m_tlast});
      if (s0_tvalid && s0_tready) acc0++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic send_beat(input int src, input logic [255:0] d, input logic last);
    beat_t b;
    int    g;
    b = mkbeat(d, last);
    g = 0;
    if (src == 0) begin
      s0_tdata = b.data; s0_tuser = b.user; s0_tkeep = b.keep; s0_tlast = last; s0_tvalid = 1'b1;
    end else begin
      s1_tdata = b.data; s1_tuser = b.user; s1_tkeep = b.keep; s1_tlast = last; s1_tvalid = 1'b1;
    end
    forever begin
      @(negedge clk);
      if ((src == 0) ? s0_tready : s1_tready) break;
      g++;
      if (g > 400) begin
        n_chk++;
        $display("FAIL in_ready_timeout: src %0d never ready", src);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (src == 0) s0_tvalid = 1'b0;
    else          s1_tvalid = 1'b0;
  endtask

  task automatic send_stream(input int src, input int n, input int len);
    for (int p = 0; p < n; p++)
      for (int b = 0; b < len; b++)
        send_beat(src, mk(src, p, b), (b == len - 1));
  endtask

  task automatic push_pkt(input int src, input int p, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(mkbeat(mk(src, p, b), (b == len - 1)));
  endtask

  // Arbitration model for two fully backlogged sources.
  task automatic build_exp(input vec_t v);
    int r0, r1, st, i0, i1;
    r0 = v.n0; r1 = v.n1; st = 0; i0 = 0; i1 = 0;
    exp_q.delete();
    while (r0 > 0 || r1 > 0) begin
      if (r1 > 0 && (r0 == 0 || st >= LIM)) begin
        push_pkt(1, i1, v.len1); i1++; r1--; st = 0;
      end else begin
        push_pkt(0, i0, v.len0); i0++; r0--; st = (r1 > 0) ? st + 1 : 0;
      end
    end
  endtask

  task automatic compare_got(input string tag);
    chk({tag, "_nbeats"}, 256'(got.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk({tag, "_data"}, got[i].data, exp_q[i].data);
      chk({tag, "_side"}, {95'h0, got[i].user, got[i].keep, got[i].last},
          {95'h0, exp_q[i].user, exp_q[i].keep, exp_q[i].last});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    acc0 = 0;
  endtask

  initial begin : main
    vec_t vecs[5];
    int   ci;
    int   gaps;
    vecs[0] = '{10, 2, 10, 2, 0, 10, 10};  // both backlogged, starvation pattern
    vecs[1] = '{0, 1, 1, 5, 1, 0, 1};      // op1 5-beat under toggled ready
    vecs[2] = '{25, 4, 0, 1, 2, 25, 0};    // 200-cycle output stall, op0 streaming
    vecs[3] = '{6, 1, 6, 1, 0, 6, 6};      // single-beat packets
    vecs[4] = '{3, 3, 3, 2, 1, 3, 3};      // mixed lengths under toggled ready

    s0_tdata = '0; s0_tuser = '0; s0_tkeep = '0; s0_tlast = 1'b0; s0_tvalid = 1'b0;
    s1_tdata = '0; s1_tuser = '0; s1_tkeep = '0; s1_tlast = 1'b0; s1_tvalid = 1'b0;
    m_tready = 1'b0;
    rst = 1'b1;

    do_reset();
    chk("rst_tvalid", {255'h0, m_tvalid}, 256'h0);
    chk("rst_tdata", m_tdata, 256'h0);
    chk("rst_side", {95'h0, m_tuser, m_tkeep, m_tlast}, 256'h0);
    chk("rst_cnt", {192'h0, cnt0, cnt1}, 256'h0);
    chk("rst_in_ready", {254'h0, s0_tready, s1_tready}, 256'h3);

    // Single op0 3-beat packet: first output two edges after first accept.
    m_tready = 1'b1;
    send_beat(0, 256'hA0, 1'b0);
    fork
      begin
        send_beat(0, 256'hA1, 1'b0);
        send_beat(0, 256'hA2, 1'b1);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t1_valid_e1", {255'h0, m_tvalid}, 256'h0);
        @(negedge clk);
        chk("t1_valid_e2", {255'h0, m_tvalid}, 256'h1);
        chk("t1_first_data", m_tdata, 256'hA0);
      end
    join
    repeat (8) @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(mkbeat(256'hA0, 1'b0));
    exp_q.push_back(mkbeat(256'hA1, 1'b0));
    exp_q.push_back(mkbeat(256'hA2, 1'b1));
    compare_got("t1");
    chk("t1_cnt", {192'h0, cnt0, cnt1}, {192'h0, 32'd1, 32'd0});

    for (int v = 0; v < 5; v++) begin
      do_reset();
      build_exp(vecs[v]);
      m_tready = (vecs[v].mode == 2) ? 1'b0 : 1'b1;
      ci = 0;
      fork
        send_stream(0, vecs[v].n0, vecs[v].len0);
        send_stream(1, vecs[v].n1, vecs[v].len1);
        begin
          while (got.size() < exp_q.size() && ci < 3000) begin
            @(posedge clk);
            #1;
            ci++;
            if (vecs[v].mode == 1) m_tready = !m_tready;
            else if (vecs[v].mode == 2) begin
              if (ci == 199) begin
                chk("stall_in_ready", {255'h0, s0_tready}, 256'h0);
                chk("stall_accepted", 256'(acc0), 256'd64);
              end
              m_tready = (ci >= 200);
            end
          end
        end
      join
      m_tready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      compare_got($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_cnt0", v), 256'(cnt0), 256'(vecs[v].exp_cnt0));
      chk($sformatf("vec%0d_cnt1", v), 256'(cnt1), 256'(vecs[v].exp_cnt1));
    end

    // op0 packet with an input gap while op1 waits; op1 must not cut in.
    do_reset();
    m_tready = 1'b1;
    gaps = 0;
    ci = 0;
    fork
      begin
        send_beat(0, mk(0, 0, 0), 1'b0);
        send_beat(0, mk(0, 0, 1), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_beat(0, mk(0, 0, 2), 1'b0);
        send_beat(0, mk(0, 0, 3), 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        send_stream(1, 1, 2);
      end
      begin
        while (got.size() < 1 && ci < 50) begin @(negedge clk); ci++; end
        while (got.size() < 4 && ci < 100) begin
          @(negedge clk);
          ci++;
          if (!m_tvalid) gaps++;
        end
      end
    join
    repeat (8) @(posedge clk);
    #1;
    exp_q.delete();
    push_pkt(0, 0, 4);
    push_pkt(1, 0, 2);
    compare_got("t5");
    chk("t5_gap_seen", 256'(gaps > 0), 256'h1);
    chk("t5_cnt", {192'h0, cnt0, cnt1}, {192'h0, 32'd1, 32'd1});

    // Reset in the middle of a stalled packet drops everything.
    m_tready = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(0, mk(0, 1, b), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_pre_valid", {255'h0, m_tvalid}, 256'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {255'h0, m_tvalid}, 256'h0);
    chk("mid_rst_data", m_tdata, 256'h0);
    chk("mid_rst_side", {95'h0, m_tuser, m_tkeep, m_tlast}, 256'h0);
    chk("mid_rst_cnt", {192'h0, cnt0, cnt1}, 256'h0);
    rst = 1'b0;
    m_tready = 1'b1;
    got.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("mid_no_resume", 256'(got.size()), 256'h0);
    chk("mid_in_ready", {254'h0, s0_tready, s1_tready}, 256'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
